dcache_data_sched: RTL and testbench
====================================

DCACHE_DATA_SCHED -- requirements
Module: dcache_data_sched

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL set the data-array address width.
REQ-002 Parameter DATA_W, default 64, SHALL set the write-data width.
REQ-003 Parameter MASK_W, default 8, SHALL set the byte write-mask width (DATA_W/8).
REQ-004 Parameter STARVE_MAX, default 8, SHALL set the number of consecutive requester-0 wins allowed while another requester waits.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 in_N_valid  input  1  (N=0..3) SHALL flag a pending data-array request from requester N.
REQ-008 in_N_ready  output  1  (N=0..3) SHALL accept requester N's request when high together with in_N_valid.
REQ-009 in_N_bits_addr/write/wdata/wmask/way_en  input  ADDR_W/1/DATA_W/MASK_W/1  (N=0..3) SHALL carry the request payload.
REQ-010 out_valid  output  1  SHALL flag a request presented to the data array.
REQ-011 out_ready  input  1  SHALL signal the data array accepts the presented request.
REQ-012 out_bits_addr/write/wdata/wmask/way_en  output  ADDR_W/1/DATA_W/MASK_W/1  SHALL carry the granted request's payload.
REQ-013 out_chosen  output  2  SHALL give the index of the granted requester.
REQ-014 resp_valid  output  1  SHALL pulse for one cycle when read data for an accepted read is available.
REQ-015 resp_id  output  2  SHALL give the requester index owning the read response.

Function
REQ-016 Requester 0 (refill) SHALL have priority over requesters 1-3 unless the starvation override (REQ-020) is active.
REQ-017 Requesters 1-3 SHALL be arbitrated round-robin: search starts at rr_ptr+1 (wrapping 3->1); rr_ptr updates to the winner only on an out handshake from requester 1-3.
REQ-018 out_valid SHALL be high when any in_N_valid is high or the lock (REQ-019) is set; out_bits and out_chosen SHALL be combinationally muxed from the selected requester.
REQ-019 When out_valid is high and out_ready low, the scheduler SHALL set a lock holding out_chosen at its current value next cycle and thereafter regardless of new higher-priority requests; the lock SHALL clear on the out handshake.
REQ-020 A 4-bit starve counter SHALL increment on each requester-0 handshake while any of in_1..3_valid is high, clear on any requester-1..3 handshake, and when equal to STARVE_MAX SHALL force the next unlocked grant to the round-robin group if any of in_1..3_valid is high.
REQ-021 in_N_ready SHALL equal out_ready AND (out_chosen==N) AND out_valid; at most one in_N_ready high per cycle.
REQ-022 On an out handshake with out_bits_write==0, resp_valid SHALL be high exactly one cycle later with resp_id equal to the handshake's out_chosen; writes SHALL produce no response.
REQ-023 Back-to-back reads SHALL produce back-to-back resp_valid pulses in acceptance order.
REQ-024 Requesters SHALL hold valid and payload stable until ready; a requester dropping valid while locked is a protocol violation, and the scheduler SHALL then drive its held payload unchanged (no recovery required).

Reset
REQ-025 While reset is low: out_valid=0 is not forced (combinational) but lock=0, rr_ptr=3 (requester 1 first), starve counter=0, resp_valid=0, resp_id=0.
REQ-026 Reset assertion mid-transaction SHALL clear lock and any pending response immediately; no resp_valid SHALL follow a read accepted in the cycle reset asserts.

Verification
REQ-027 All four valid, out_ready=1 continuously, requester 0 writes -> grants 0 x8, then 1, then 0 x8, then 2, then 0 x8, then 3.
REQ-028 Requesters 1,2,3 valid only, out_ready=1 -> out_chosen sequence 1,2,3,1,2,3.
REQ-029 Requester 2 valid, out_ready=0 for 3 cycles, requester 0 asserts at cycle 1 -> out_chosen stays 2 until out_ready=1, then 0 next.
REQ-030 Read from requester 3 accepted at cycle T -> resp_valid=1, resp_id=3 at T+1 only; write from requester 1 at T+1 -> no resp_valid at T+2.
REQ-031 Reset low asserted during locked stall with rr_ptr=2 -> after release, lock=0, resp_valid=0, requesters 1-3 valid grants 1 first.

Source files
------------

// File: rtl/dcache_data_sched.sv
// dcache_data_sched: arbitrates four data-array requesters onto one port.
// Requester 0 (refill) wins by default; requesters 1-3 share round-robin.
// A stalled grant is locked until accepted, a starve counter bounds how long
// the refill port can shut out the others, and accepted reads return a
// one-cycle response tag.
module dcache_data_sched #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 64,
    parameter int MASK_W     = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_0_valid,
    output logic              in_0_ready,
    input  logic [ADDR_W-1:0] in_0_bits_addr,
    input  logic              in_0_bits_write,
    input  logic [DATA_W-1:0] in_0_bits_wdata,
    input  logic [MASK_W-1:0] in_0_bits_wmask,
    input  logic              in_0_bits_way_en,
    input  logic              in_1_valid,
    output logic              in_1_ready,
    input  logic [ADDR_W-1:0] in_1_bits_addr,
    input  logic              in_1_bits_write,
    input  logic [DATA_W-1:0] in_1_bits_wdata,
    input  logic [MASK_W-1:0] in_1_bits_wmask,
    input  logic              in_1_bits_way_en,
    input  logic              in_2_valid,
    output logic              in_2_ready,
    input  logic [ADDR_W-1:0] in_2_bits_addr,
    input  logic              in_2_bits_write,
    input  logic [DATA_W-1:0] in_2_bits_wdata,
    input  logic [MASK_W-1:0] in_2_bits_wmask,
    input  logic              in_2_bits_way_en,
    input  logic              in_3_valid,
    output logic              in_3_ready,
    input  logic [ADDR_W-1:0] in_3_bits_addr,
    input  logic              in_3_bits_write,
    input  logic [DATA_W-1:0] in_3_bits_wdata,
    input  logic [MASK_W-1:0] in_3_bits_wmask,
    input  logic              in_3_bits_way_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_bits_addr,
    output logic              out_bits_write,
    output logic [DATA_W-1:0] out_bits_wdata,
    output logic [MASK_W-1:0] out_bits_wmask,
    output logic              out_bits_way_en,
    output logic [1:0]        out_chosen,
    output logic              resp_valid,
    output logic [1:0]        resp_id
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Requester payloads gathered into arrays so the output mux is one index.
    logic [3:0]        valid_vec;
    logic [3:0]        write_vec;
    logic [3:0]        way_vec;
    logic [ADDR_W-1:0] addr_vec  [4];
    logic [DATA_W-1:0] wdata_vec [4];
    logic [MASK_W-1:0] wmask_vec [4];

    assign valid_vec = {in_3_valid, in_2_valid, in_1_valid, in_0_valid};
    assign write_vec = {in_3_bits_write, in_2_bits_write, in_1_bits_write, in_0_bits_write};
    assign way_vec   = {in_3_bits_way_en, in_2_bits_way_en, in_1_bits_way_en, in_0_bits_way_en};
    assign addr_vec[0]  = in_0_bits_addr;
    assign addr_vec[1]  = in_1_bits_addr;
    assign addr_vec[2]  = in_2_bits_addr;
    assign addr_vec[3]  = in_3_bits_addr;
    assign wdata_vec[0] = in_0_bits_wdata;
    assign wdata_vec[1] = in_1_bits_wdata;
    assign wdata_vec[2] = in_2_bits_wdata;
    assign wdata_vec[3] = in_3_bits_wdata;
    assign wmask_vec[0] = in_0_bits_wmask;
    assign wmask_vec[1] = in_1_bits_wmask;
    assign wmask_vec[2] = in_2_bits_wmask;
    assign wmask_vec[3] = in_3_bits_wmask;

    logic       lock;        // a stalled grant is pinned until accepted
    logic [1:0] lock_id;
    logic [1:0] rr_ptr;      // last round-robin winner, always 1..3
    logic [3:0] starve_cnt;  // refill wins while the group was waiting

    logic       any_rr;
    logic       rr_hit;
    logic [2:0] cand;
    logic [1:0] rr_id;
    logic       starve_force;
    logic [1:0] sel;
    logic       handshake;

    assign any_rr       = |valid_vec[3:1];
    assign starve_force = (starve_cnt == STARVE_LIM) && any_rr;

    // Round-robin search over requesters 1-3, starting after rr_ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rr_id  = 2'd1;
        rr_hit = 1'b0;
        cand   = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand > 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!rr_hit && valid_vec[cand[1:0]]) begin
                rr_hit = 1'b1;
                rr_id  = cand[1:0];
            end
        end
    end

    // Grant selection: lock, then starvation override, then refill, then group.
    always_comb begin
        sel = 2'd0;
        if (lock) begin
            sel = lock_id;
        end else if (starve_force) begin
            sel = rr_id;
        end else if (valid_vec[0]) begin
            sel = 2'd0;
        end else if (any_rr) begin
            sel = rr_id;
        end
    end

    assign out_valid       = (|valid_vec) || lock;
    assign handshake       = out_valid && out_ready;
    assign out_chosen      = sel;
    assign out_bits_addr   = addr_vec[sel];
    assign out_bits_write  = write_vec[sel];
    assign out_bits_wdata  = wdata_vec[sel];
    assign out_bits_wmask  = wmask_vec[sel];
    assign out_bits_way_en = way_vec[sel];

    assign in_0_ready = handshake && (sel == 2'd0);
    assign in_1_ready = handshake && (sel == 2'd1);
    assign in_2_ready = handshake && (sel == 2'd2);
    assign in_3_ready = handshake && (sel == 2'd3);

    // Lock bookkeeping: pin the current grant while the array stalls it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock    <= 1'b0;
            lock_id <= 2'd0;
        end else if (handshake) begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values regardless of block evaluation order.
            lock    <= 1'b0;
        end else if (out_valid) begin
            lock    <= 1'b1;
            lock_id <= sel;
        end
    end

    // Fairness state: round-robin pointer and refill starve counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= 2'd3;
            starve_cnt <= 4'd0;
        end else if (handshake) begin
            if (sel == 2'd0) begin
                if (any_rr) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                rr_ptr     <= sel;
                starve_cnt <= 4'd0;
            end
        end
    end

    // Read response tag, one cycle after an accepted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_id    <= 2'd0;
        end else begin
            resp_valid <= handshake && !out_bits_write;
            if (handshake && !out_bits_write) begin
                resp_id <= sel;
            end
        end
    end

endmodule

// File: tb/tb_dcache_data_sched.sv
// tb_dcache_data_sched: directed scenarios plus randomized traffic, checked by
// a cycle-level reference model and a response scoreboard.
module tb_dcache_data_sched;

    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 64;
    localparam int MASK_W     = 8;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] v = '0;
    logic [3:0] wr = '0;
    logic [3:0] we = '0;
    logic [ADDR_W-1:0] a [4];
    logic [DATA_W-1:0] d [4];
    logic [MASK_W-1:0] m [4];
    logic out_ready = 1'b0;

    wire rdy0, rdy1, rdy2, rdy3;
    wire [3:0] rdy = {rdy3, rdy2, rdy1, rdy0};
    wire              out_valid;
    wire [ADDR_W-1:0] out_bits_addr;
    wire              out_bits_write;
    wire [DATA_W-1:0] out_bits_wdata;
    wire [MASK_W-1:0] out_bits_wmask;
    wire              out_bits_way_en;
    wire [1:0]        out_chosen;
    wire              resp_valid;
    wire [1:0]        resp_id;

    dcache_data_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
                        .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .in_0_valid(v[0]), .in_0_ready(rdy0), .in_0_bits_addr(a[0]), .in_0_bits_write(wr[0]),
        .in_0_bits_wdata(d[0]), .in_0_bits_wmask(m[0]), .in_0_bits_way_en(we[0]),
        .in_1_valid(v[1]), .in_1_ready(rdy1), .in_1_bits_addr(a[1]), .in_1_bits_write(wr[1]),
        .in_1_bits_wdata(d[1]), .in_1_bits_wmask(m[1]), .in_1_bits_way_en(we[1]),
        .in_2_valid(v[2]), .in_2_ready(rdy2), .in_2_bits_addr(a[2]), .in_2_bits_write(wr[2]),
        .in_2_bits_wdata(d[2]), .in_2_bits_wmask(m[2]), .in_2_bits_way_en(we[2]),
        .in_3_valid(v[3]), .in_3_ready(rdy3), .in_3_bits_addr(a[3]), .in_3_bits_write(wr[3]),
        .in_3_bits_wdata(d[3]), .in_3_bits_wmask(m[3]), .in_3_bits_way_en(we[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits_addr(out_bits_addr),
        .out_bits_write(out_bits_write), .out_bits_wdata(out_bits_wdata),
        .out_bits_wmask(out_bits_wmask), .out_bits_way_en(out_bits_way_en),
        .out_chosen(out_chosen), .resp_valid(resp_valid), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct { int id; int due; } resp_t;
    resp_t sb[$];
    int    grant_log[$];
    bit [3:0] hs_flag = '0;
    bit    check_en = 1'b0;

    // Reference model state: what the scheduler must remember between cycles.
    int m_lock, m_lch, m_rr, m_starve;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_lch = 0; m_rr = 3; m_starve = 0;
        sb.delete();
        grant_log.delete();
        hs_flag = '0;
    endtask

    // Round-robin winner: first valid requester after the last winner, 1..3.
    function automatic int rr_pick();
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = ((m_rr - 1 + k) % 3) + 1;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int model_pick();
        int g;
        g = rr_pick();
        if (m_lock != 0) return m_lch;
        if (m_starve == STARVE_MAX && g > 0) return g;
        if (v[0]) return 0;
        return g;
    endfunction

    // Per-cycle checker: compare grant, payload and readies, then advance model.
    always @(negedge clk) begin : chk
        int e;
        bit grp;
        if (reset && check_en) begin
            e   = model_pick();
            grp = |v[3:1];
            check("out_valid", 64'(out_valid), 64'(e >= 0));
            if (e >= 0) begin
                check("out_chosen", 64'(out_chosen), 64'(e));
                check("out_addr", 64'(out_bits_addr), 64'(a[e]));
                check("out_write", 64'(out_bits_write), 64'(wr[e]));
                check("out_wdata", out_bits_wdata, d[e]);
                check("out_wmask", 64'(out_bits_wmask), 64'(m[e]));
                check("out_way_en", 64'(out_bits_way_en), 64'(we[e]));
            end
            for (int n = 0; n < 4; n++) begin
                check("in_ready", 64'(rdy[n]), 64'(out_ready && e == n));
            end
            if (e >= 0 && out_ready) begin
                grant_log.push_back(e);
                hs_flag[e] = 1'b1;
                if (!wr[e]) sb.push_back('{id: e, due: cyc + 1});
                if (e == 0) begin
                    if (grp) m_starve = (m_starve + 1) % 16;
                end else begin
                    m_starve = 0;
                    m_rr = e;
                end
                m_lock = 0;
            end else if (e >= 0) begin
                m_lock = 1;
                m_lch = e;
            end
        end
    end

    // Response monitor: every resp_valid must match the oldest pending read.
    always @(negedge clk) begin : mon
        resp_t r;
        if (reset && check_en) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    r = sb.pop_front();
                    check("resp_id", 64'(resp_id), 64'(r.id));
                    check("resp_cycle", 64'(cyc), 64'(r.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("resp_missing", 64'(resp_valid), 64'd1);
                r = sb.pop_front();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int n, bit write);
        a[n]  = ADDR_W'($urandom);
        d[n]  = {$urandom, $urandom};
        m[n]  = MASK_W'($urandom);
        we[n] = 1'($urandom_range(0, 1));
        wr[n] = write;
    endtask

    // Assert reset for two edges, check reset outputs, release after an edge.
    task automatic do_reset();
        check_en  = 1'b0;
        reset     = 1'b0;
        v         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        model_reset();
        reset    = 1'b1;
        check_en = 1'b1;
    endtask

    task automatic drain();
        v = '0;
        repeat (3) step();
    endtask

    int exp_seq[$];
    int pr0, prx, prr;

    initial begin
        for (int n = 0; n < 4; n++) set_req(n, 1'b1);
        model_reset();
        do_reset();
        @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        step();

        // Starvation bound: refill writes saturate, group gets one slot per 8.
        do_reset();
        for (int n = 0; n < 4; n++) set_req(n, 1'b1);
        v = 4'hF; out_ready = 1'b1;
        repeat (27) step();
        drain();
        exp_seq.delete();
        for (int g = 1; g <= 3; g++) begin
            repeat (STARVE_MAX) exp_seq.push_back(0);
            exp_seq.push_back(g);
        end
        check("starve_len", 64'(grant_log.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
            check("starve_seq", 64'(grant_log[i]), 64'(exp_seq[i]));

        // Pure round-robin among reads from 1..3, back-to-back responses.
        do_reset();
        for (int n = 1; n < 4; n++) set_req(n, 1'b0);
        v = 4'b1110; out_ready = 1'b1;
        repeat (6) step();
        drain();
        check("rr_len", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check("rr_seq", 64'(grant_log[i]), 64'((i % 3) + 1));

        // Lock: stalled grant to 2 survives a refill request.
        do_reset();
        set_req(2, 1'b0); set_req(0, 1'b1);
        v = 4'b0100; out_ready = 1'b0;
        @(negedge clk); check("lock_c0", 64'(out_chosen), 64'd2);
        step(); v[0] = 1'b1;
        repeat (2) begin
            @(negedge clk); check("lock_hold", 64'(out_chosen), 64'd2);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk); check("lock_release", 64'(out_chosen), 64'd2);
        step(); v[2] = 1'b0;
        @(negedge clk); check("lock_after", 64'(out_chosen), 64'd0);
        step();
        drain();

        // Read response timing; a following write yields nothing.
        do_reset();
        set_req(3, 1'b0); set_req(1, 1'b1);
        v = 4'b1000; out_ready = 1'b1;
        step(); v = 4'b0010;
        @(negedge clk);
        check("read_resp_valid", 64'(resp_valid), 64'd1);
        check("read_resp_id", 64'(resp_id), 64'd3);
        step(); v = '0;
        @(negedge clk); check("write_no_resp", 64'(resp_valid), 64'd0);
        step();
        drain();

        // Reset right after a read is accepted kills its response.
        do_reset();
        set_req(1, 1'b0);
        v = 4'b0010; out_ready = 1'b1;
        @(posedge clk);
        #2;
        check_en = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_kills_resp", 64'(resp_valid), 64'd0);

        // Reset during a locked stall with rr_ptr=2 restores defaults.
        do_reset();
        set_req(2, 1'b0); set_req(0, 1'b0);
        v = 4'b0100; out_ready = 1'b1;
        step();
        v = 4'b0001; out_ready = 1'b0;
        step();
        @(negedge clk); check("stall_locked", 64'(out_chosen), 64'd0);
        #1;
        do_reset();
        for (int n = 1; n < 4; n++) set_req(n, 1'b0);
        v = 4'b1110; out_ready = 1'b1;
        @(negedge clk); check("post_rst_first", 64'(out_chosen), 64'd1);
        step();
        drain();

        // Randomized traffic at three pressure profiles.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            pr0 = (round == 0) ? 90 : (round == 1) ? 30 : 100;
            prx = (round == 0) ? 60 : (round == 1) ? 30 : 100;
            prr = (round == 0) ? 80 : (round == 1) ? 50 : 70;
            for (int c = 0; c < 400; c++) begin
                for (int n = 0; n < 4; n++) begin
                    if (hs_flag[n]) begin
                        v[n] = 1'b0;
                        hs_flag[n] = 1'b0;
                    end
                    if (!v[n] && $urandom_range(0, 99) < ((n == 0) ? pr0 : prx)) begin
                        set_req(n, 1'($urandom_range(0, 1)));
                        v[n] = 1'b1;
                    end
                end
                out_ready = ($urandom_range(0, 99) < prr);
                step();
            end
            out_ready = 1'b1;
            repeat (4) begin
                for (int n = 0; n < 4; n++) begin
                    if (hs_flag[n]) begin
                        v[n] = 1'b0;
                        hs_flag[n] = 1'b0;
                    end
                end
                step();
            end
            drain();
            check("sb_empty", 64'(sb.size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
